gen_arb_wrr_top: RTL

Weighted round-robin arbiter with registered, handshaked grants. It is the next generation of the round-robin arbiter. A granted requester keeps the grant for up to its programmed weight of accepted beats, then priority rotates to the requester above it. With all weights at 1 it reduces to plain round-robin, lsb highest priority after reset. It sits between multiple initiators and one shared resource (bus, memory port, FIFO write side) that acknowledges each transferred beat.

---
 rtl/gen_arb_wrr_top.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gen_arb_wrr_top.sv
// Weighted round-robin arbiter with registered one-hot grants and per-beat credit accounting.
// Latency: request to grant 1 cycle; release to next grant 0 idle cycles (back-to-back reload).
// Backpressure: gnt_ack=0 holds the grant and its credits; a withdrawn request releases without consuming a beat.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst_n    - asynchronous reset, asserted HIGH despite the name (legacy port name)
//   rqsts    - level-sensitive request bus, one bit per requester
//   wghts    - packed per-requester weights, requester i at [i*CRD_W +: CRD_W], 0 treated as 1
//   gnt_ack  - resource accepted one beat from the current grantee (ignored while idle)
//   grnts    - registered one-hot grant or all zeros
//   gnt_vld  - registered, equals |grnts
//   gnt_idx  - registered binary index of grantee, holds last value while idle

module gen_arb_wrr_top #(
   parameter int WID   = 8,
   parameter int CRD_W = 4,
   parameter int IDX_W = (WID > 1) ? $clog2(WID) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WID-1:0]       rqsts,
   input  logic [WID*CRD_W-1:0] wghts,
   input  logic                 gnt_ack,
   output logic [WID-1:0]       grnts,
   output logic                 gnt_vld,
   output logic [IDX_W-1:0]     gnt_idx
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // State
   logic [0:0]       r_state;
   logic [WID-1:0]   r_mask;
   logic [CRD_W-1:0] r_crd_cnt;
   logic [IDX_W-1:0] r_cur;
   logic [WID-1:0]   r_grnts;
   logic             r_gnt_vld;

   // Combinational
   logic             w_cur_req;
   logic             w_crd_last;
   logic             w_release;
   logic [WID-1:0]   w_mask_rel;
   logic [WID-1:0]   w_mask_use;
   logic [WID-1:0]   w_masked;
   logic [IDX_W-1:0] w_pick_msk;
   logic [IDX_W-1:0] w_pick_base;
   logic [IDX_W-1:0] w_pick;
   logic             w_pick_vld;
   logic [CRD_W-1:0] w_wght;
   logic [CRD_W-1:0] w_load_crd;

   assign w_cur_req  = rqsts[r_cur];
   assign w_crd_last = (r_crd_cnt == CRD_W'(1));

   // Release when the requester withdrew (ack or not), or when the last credit is acked.
   assign w_release = (r_state == ST_GRANT) && (!w_cur_req || (gnt_ack && w_crd_last));

   // Priority after release rotates to the requesters strictly above the current grantee.
   always_comb begin
      w_mask_rel = '0;
      for (int i = 0; i < WID; i++) begin
         w_mask_rel[i] = (i > int'(r_cur));
      end
   end

   // The releasing cycle arbitrates with the mask it is about to write, so the
   // next grantee loads on the same edge without an idle cycle.
   assign w_mask_use = w_release ? w_mask_rel : r_mask;
   assign w_masked   = rqsts & w_mask_use;
   assign w_pick_vld = |rqsts;

   // Two lowest-set-bit encoders; scanning downward lets the lowest index win.
   always_comb begin
      w_pick_msk  = '0;
      w_pick_base = '0;
      for (int i = WID - 1; i >= 0; i--) begin
         if (w_masked[i]) begin
            w_pick_msk = IDX_W'(i);
         end
         if (rqsts[i]) begin
            w_pick_base = IDX_W'(i);
         end
      end
   end

   // Fall back to base priority when nothing above the last grantee is requesting.
   assign w_pick = (|w_masked) ? w_pick_msk : w_pick_base;

   always_comb begin
      w_wght = '0;
      for (int i = 0; i < WID; i++) begin
         if (w_pick == IDX_W'(i)) begin
            w_wght = wghts[i*CRD_W +: CRD_W];
         end
      end
   end

   assign w_load_crd = (w_wght == '0) ? CRD_W'(1) : w_wght;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state   <= ST_IDLE;
         r_mask    <= '1;
         r_crd_cnt <= '0;
         r_cur     <= '0;
         r_grnts   <= '0;
         r_gnt_vld <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_state   <= ST_GRANT;
                  r_grnts   <= WID'(1) << w_pick;
                  r_gnt_vld <= 1'b1;
                  r_cur     <= w_pick;
                  r_crd_cnt <= w_load_crd;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_mask <= w_mask_rel;
                  if (w_pick_vld) begin
                     // Weight is sampled only here, so mid-grant weight changes wait for the next load.
                     r_grnts   <= WID'(1) << w_pick;
                     r_gnt_vld <= 1'b1;
                     r_cur     <= w_pick;
                     r_crd_cnt <= w_load_crd;
                  end else begin
                     r_state   <= ST_IDLE;
                     r_grnts   <= '0;
                     r_gnt_vld <= 1'b0;
                  end
               end else if (gnt_ack) begin
                  r_crd_cnt <= r_crd_cnt - CRD_W'(1);
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_grnts   <= '0;
               r_gnt_vld <= 1'b0;
            end
         endcase
      end
   end

   assign grnts   = r_grnts;
   assign gnt_vld = r_gnt_vld;
   // The grantee index register doubles as the output; it is only written on a load.
   assign gnt_idx = r_cur;

endmodule
